// File: rtl/bist_pattern_engine.sv
// Purpose: on-chip BIST; a Galois LFSR drives patterns into the CUT and a Galois MISR compacts its responses.
// Latency: pattern 0 appears the cycle after start; done rises NUM_PATTERNS cycles later.
// Backpressure: none; one pattern per cycle, abort cancels a run and start is ignored while running.

`default_nettype none

module bist_pattern_engine #(
    parameter int                    IN_WIDTH         = 7,
    parameter int                    OUT_WIDTH        = 4,
    parameter logic [IN_WIDTH-1:0]   TPG_TAPS         = 7'h03,
    parameter logic [IN_WIDTH-1:0]   TPG_SEED         = 7'h01,
    parameter int                    MISR_WIDTH       = 8,
    parameter logic [MISR_WIDTH-1:0] MISR_TAPS        = 8'h1D,
    parameter int                    NUM_PATTERNS     = 100,
    parameter logic [MISR_WIDTH-1:0] GOLDEN_SIGNATURE = 8'h00
) (
    input  logic                                  clock,
    input  logic                                  reset_n,
    input  logic                                  start,
    input  logic                                  abort,
    input  logic [OUT_WIDTH-1:0]                  test_response,
    output logic [IN_WIDTH-1:0]                   test_pattern,
    output logic                                  test_mode,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  pass,
    output logic [MISR_WIDTH-1:0]                 signature,
    output logic [$clog2(NUM_PATTERNS+1)-1:0]     pattern_count
);

    localparam int CNT_W = $clog2(NUM_PATTERNS + 1);

    // The count reaching this value on a RUN edge marks the final capture.
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_PATTERNS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]            state_q;
    logic [1:0]            state_d;
    logic [IN_WIDTH-1:0]   lfsr_q;
    logic [IN_WIDTH-1:0]   lfsr_d;
    logic [MISR_WIDTH-1:0] misr_q;
    logic [MISR_WIDTH-1:0] misr_d;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_d;

    logic [IN_WIDTH-1:0]   lfsr_step;
    logic [MISR_WIDTH-1:0] misr_step;
    logic                  in_run;
    logic                  in_done;

    // Galois shift-left forms: the bit shifted out of the MSB folds the tap mask back in.
    assign lfsr_step = {lfsr_q[IN_WIDTH-2:0], 1'b0}
                     ^ (lfsr_q[IN_WIDTH-1] ? TPG_TAPS : '0);

    // The response is zero-extended into the low bits of the MISR on every capture.
    assign misr_step = {misr_q[MISR_WIDTH-2:0], 1'b0}
                     ^ (misr_q[MISR_WIDTH-1] ? MISR_TAPS : '0)
                     ^ MISR_WIDTH'(test_response);

    // Next-state selection: abort wins over the final capture, start only acts outside RUN.
    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        misr_d  = misr_q;
        count_d = count_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    lfsr_d  = TPG_SEED;
                    misr_d  = '0;
                    count_d = '0;
                end
            end
            S_RUN: begin
                if (abort) begin
                    // Signature and count are left as-is so they can be inspected afterwards.
                    state_d = S_IDLE;
                end else begin
                    lfsr_d  = lfsr_step;
                    misr_d  = misr_step;
                    count_d = count_q + CNT_ONE;
                    if (count_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset parks the engine idle with a cleared signature.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            lfsr_q  <= TPG_SEED;
            misr_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            misr_q  <= misr_d;
            count_q <= count_d;
        end
    end

    // Outputs are pure decodes of registered state; the LFSR is hidden from the CUT outside RUN.
    assign in_run        = (state_q == S_RUN);
    assign in_done       = (state_q == S_DONE);
    assign test_pattern  = in_run ? lfsr_q : '0;
    assign test_mode     = in_run;
    assign busy          = in_run;
    assign done          = in_done;
    assign pass          = in_done && (misr_q == GOLDEN_SIGNATURE);
    assign signature     = misr_q;
    assign pattern_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_bist_pattern_engine.sv
// Purpose: self-checking bench for bist_pattern_engine over four parameterisations.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: not applicable; stimulus is cycle-exact.

module tb_bist_pattern_engine;

    localparam logic [6:0] M_TPG_TAPS  = 7'h03;
    localparam logic [6:0] M_TPG_SEED  = 7'h01;
    localparam logic [7:0] M_MISR_TAPS = 8'h1D;

    typedef struct {
        logic [3:0] resp;
        logic [6:0] pat;
        logic [7:0] sig;
    } vec_t;

    logic clock;
    logic reset_n;

    // Instance A: NUM_PATTERNS=8, golden 00
    logic       a_start, a_abort;
    logic [3:0] a_resp;
    logic [6:0] a_pat;
    logic       a_mode, a_busy, a_done, a_pass;
    logic [7:0] a_sig;
    logic [3:0] a_cnt;

    // Instances B/C: NUM_PATTERNS=3, golden 2D / 2C, shared stimulus
    logic       bc_start, bc_abort;
    logic [3:0] bc_resp;
    logic [6:0] b_pat, c_pat;
    logic       b_mode, b_busy, b_done, b_pass;
    logic       c_mode, c_busy, c_done, c_pass;
    logic [7:0] b_sig, c_sig;
    logic [1:0] b_cnt, c_cnt;

    // Instance D: NUM_PATTERNS=1
    logic       d_start, d_abort;
    logic [3:0] d_resp;
    logic [6:0] d_pat;
    logic       d_mode, d_busy, d_done, d_pass;
    logic [7:0] d_sig;
    logic [0:0] d_cnt;

    int tests;
    int fails;
    logic [7:0] sb_q[$];
    vec_t tbl[8];

    bist_pattern_engine #(.NUM_PATTERNS(8)) u_a (
        .clock(clock), .reset_n(reset_n), .start(a_start), .abort(a_abort),
        .test_response(a_resp), .test_pattern(a_pat), .test_mode(a_mode),
        .busy(a_busy), .done(a_done), .pass(a_pass), .signature(a_sig),
        .pattern_count(a_cnt)
    );

    bist_pattern_engine #(.NUM_PATTERNS(3), .GOLDEN_SIGNATURE(8'h2D)) u_b (
        .clock(clock), .reset_n(reset_n), .start(bc_start), .abort(bc_abort),
        .test_response(bc_resp), .test_pattern(b_pat), .test_mode(b_mode),
        .busy(b_busy), .done(b_done), .pass(b_pass), .signature(b_sig),
        .pattern_count(b_cnt)
    );

    bist_pattern_engine #(.NUM_PATTERNS(3), .GOLDEN_SIGNATURE(8'h2C)) u_c (
        .clock(clock), .reset_n(reset_n), .start(bc_start), .abort(bc_abort),
        .test_response(bc_resp), .test_pattern(c_pat), .test_mode(c_mode),
        .busy(c_busy), .done(c_done), .pass(c_pass), .signature(c_sig),
        .pattern_count(c_cnt)
    );

    bist_pattern_engine #(.NUM_PATTERNS(1)) u_d (
        .clock(clock), .reset_n(reset_n), .start(d_start), .abort(d_abort),
        .test_response(d_resp), .test_pattern(d_pat), .test_mode(d_mode),
        .busy(d_busy), .done(d_done), .pass(d_pass), .signature(d_sig),
        .pattern_count(d_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Reference LFSR step, evaluated bit by bit.
    function automatic logic [6:0] m_lfsr(input logic [6:0] s);
        logic [6:0] r;
        r[0] = s[6] & M_TPG_TAPS[0];
        for (int b = 1; b < 7; b++) r[b] = s[b-1] ^ (s[6] & M_TPG_TAPS[b]);
        return r;
    endfunction

    // Reference MISR step, evaluated bit by bit.
    function automatic logic [7:0] m_misr(input logic [7:0] s, input logic [3:0] resp);
        logic [7:0] r;
        logic [7:0] e;
        e = {4'b0000, resp};
        r[0] = (s[7] & M_MISR_TAPS[0]) ^ e[0];
        for (int b = 1; b < 8; b++) r[b] = s[b-1] ^ (s[7] & M_MISR_TAPS[b]) ^ e[b];
        return r;
    endfunction

    initial begin
        logic [6:0] m_l;
        logic [7:0] m_s;
        logic [7:0] exp_sig;
        logic [7:0] bc_exp[3];

        tests = 0;
        fails = 0;
        reset_n = 1'b0;
        a_start = 0; a_abort = 0; a_resp = '0;
        bc_start = 0; bc_abort = 0; bc_resp = '0;
        d_start = 0; d_abort = 0; d_resp = '0;

        tbl[0] = '{4'h0, 7'h01, 8'h00};
        tbl[1] = '{4'h0, 7'h02, 8'h00};
        tbl[2] = '{4'h0, 7'h04, 8'h00};
        tbl[3] = '{4'h0, 7'h08, 8'h00};
        tbl[4] = '{4'h0, 7'h10, 8'h00};
        tbl[5] = '{4'h0, 7'h20, 8'h00};
        tbl[6] = '{4'h0, 7'h40, 8'h00};
        tbl[7] = '{4'h0, 7'h03, 8'h00};
        bc_exp[0] = 8'h0F;
        bc_exp[1] = 8'h11;
        bc_exp[2] = 8'h2D;

        // Reset state
        tick(); tick();
        chk("rst_pat", a_pat, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_pass", a_pass, 0);
        chk("rst_sig", a_sig, 0);
        chk("rst_cnt", a_cnt, 0);
        chk("rst_pass_b", b_pass, 0);
        reset_n = 1'b1;
        tick();
        chk("idle_busy", a_busy, 0);

        // Pattern sequence, table-driven
        a_start = 1; tick(); a_start = 0;
        for (int i = 0; i < 8; i++) begin
            a_resp = tbl[i].resp;
            chk("seq_pat", a_pat, tbl[i].pat);
            chk("seq_mode", a_mode, 1);
            chk("seq_cnt", a_cnt, i);
            sb_q.push_back(tbl[i].sig);
            tick();
            exp_sig = sb_q.pop_front();
            chk("seq_sig", a_sig, exp_sig);
            chk("seq_done", a_done, (i == 7) ? 1 : 0);
        end
        chk("seq_pass", a_pass, 1);
        chk("seq_cnt_end", a_cnt, 8);
        chk("seq_pat_end", a_pat, 0);
        chk("seq_mode_end", a_mode, 0);
        chk("seq_busy_end", a_busy, 0);

        // MISR compaction with two goldens
        bc_resp = 4'hF;
        bc_start = 1; tick(); bc_start = 0;
        for (int i = 0; i < 3; i++) begin
            sb_q.push_back(bc_exp[i]);
            tick();
            exp_sig = sb_q.pop_front();
            chk("misr_sig_b", b_sig, exp_sig);
            chk("misr_sig_c", c_sig, exp_sig);
        end
        chk("misr_done_b", b_done, 1);
        chk("misr_pass_b", b_pass, 1);
        chk("misr_done_c", c_done, 1);
        chk("misr_pass_c", c_pass, 0);

        // Abort in the third RUN cycle
        a_resp = 4'hF;
        a_start = 1; tick(); a_start = 0;
        tick(); tick();
        chk("abort_pat2", a_pat, 7'h04);
        a_abort = 1; tick(); a_abort = 0;
        chk("abort_busy", a_busy, 0);
        chk("abort_done", a_done, 0);
        chk("abort_sig", a_sig, 8'h11);
        chk("abort_cnt", a_cnt, 2);
        chk("abort_pat", a_pat, 0);
        tick(); tick();
        chk("abort_hold_sig", a_sig, 8'h11);
        chk("abort_hold_busy", a_busy, 0);

        // Random responses against the reference model, start pulsed mid-run
        m_l = M_TPG_SEED;
        m_s = 8'h00;
        a_start = 1; tick(); a_start = 0;
        for (int i = 0; i < 8; i++) begin
            a_resp = 4'($urandom_range(0, 15));
            a_start = (i == 3);
            chk("rnd_pat", a_pat, m_l);
            chk("rnd_cnt", a_cnt, i);
            m_s = m_misr(m_s, a_resp);
            m_l = m_lfsr(m_l);
            sb_q.push_back(m_s);
            tick();
            exp_sig = sb_q.pop_front();
            chk("rnd_sig", a_sig, exp_sig);
        end
        a_start = 0;
        chk("rnd_done", a_done, 1);
        chk("rnd_cnt_end", a_cnt, 8);
        chk("rnd_pass", a_pass, (m_s == 8'h00) ? 1 : 0);

        // Restart from DONE
        a_resp = 4'hF;
        a_start = 1; tick(); a_start = 0;
        chk("rs_done", a_done, 0);
        chk("rs_pat", a_pat, 7'h01);
        chk("rs_sig", a_sig, 8'h00);
        chk("rs_cnt", a_cnt, 0);
        tick();
        chk("rs_sig1", a_sig, 8'h0F);
        chk("rs_pat1", a_pat, 7'h02);

        // Asynchronous reset in the fifth RUN cycle
        tick(); tick(); tick();
        chk("mr_pat4", a_pat, 7'h10);
        #3;
        reset_n = 1'b0;
        #1;
        chk("mr_pat", a_pat, 0);
        chk("mr_mode", a_mode, 0);
        chk("mr_busy", a_busy, 0);
        chk("mr_done", a_done, 0);
        chk("mr_pass", a_pass, 0);
        chk("mr_sig", a_sig, 0);
        chk("mr_cnt", a_cnt, 0);
        #2;
        reset_n = 1'b1;
        tick(); tick(); tick();
        chk("mr_idle_busy", a_busy, 0);
        chk("mr_idle_pat", a_pat, 0);
        chk("mr_idle_done", a_done, 0);

        // Single-pattern run
        d_resp = 4'h5;
        d_start = 1; tick(); d_start = 0;
        chk("one_pat", d_pat, 7'h01);
        chk("one_busy", d_busy, 1);
        tick();
        chk("one_done", d_done, 1);
        chk("one_sig", d_sig, 8'h05);
        chk("one_busy_end", d_busy, 0);
        chk("one_pat_end", d_pat, 0);
        chk("one_cnt", d_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
